// File: rtl/counter_pkg.sv
// Shared constants and parameter legality check for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width must be at least 1 and the modulus must fit in 2..2**width.
  function automatic bit params_legal(input int unsigned width, input longint unsigned modulus);
    bit ok_s;
    if ((width < 32'd1) || (width > 32'd62)) begin
      ok_s = 1'b0;
    end else begin
      ok_s = (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/dff_sync_r.sv
// Register bank with synchronous active-high reset to zero; exposes true and inverted outputs.
module dff_sync_r #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b
);

  logic [WIDTH-1:0] r_q;

  // State register: reset wins, otherwise capture d every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= d;
    end
  end

  assign q   = r_q;
  assign q_b = ~r_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with enable, clamped parallel load, wrap/saturate modes
// and terminal-count, wrap-pulse and sticky saturation flags.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat_hit
);

  if (!params_legal(WIDTH, longint'(MODULUS))) begin : g_bad_params
    $error("sync_updown_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 32'd1);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_b;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap;
  logic             w_wrap_b;
  logic             w_wrap_nxt;
  logic             w_sat;
  logic             w_sat_b;
  logic             w_sat_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_unused_qb;

  assign w_at_max    = (w_q == MAX_VAL);
  assign w_at_zero   = &w_q_b;
  assign w_unused_qb = w_wrap_b ^ w_sat_b;

  // Next-state: load beats count; bounds are tested before stepping so no overflow.
  always_comb begin
    w_q_nxt    = w_q;
    w_wrap_nxt = 1'b0;
    w_sat_nxt  = w_sat;
    if (load) begin
      w_sat_nxt = 1'b0;
      if (load_val > MAX_VAL) begin
        w_q_nxt = MAX_VAL;
      end else begin
        w_q_nxt = load_val;
      end
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (!w_at_max) begin
          w_q_nxt = w_q + ONE_VAL;
        end else if (sat_mode == MODE_WRAP) begin
          w_q_nxt    = ZERO_VAL;
          w_wrap_nxt = 1'b1;
        end else begin
          w_sat_nxt = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_q_nxt = w_q - ONE_VAL;
        end else if (sat_mode == MODE_WRAP) begin
          w_q_nxt    = MAX_VAL;
          w_wrap_nxt = 1'b1;
        end else begin
          w_sat_nxt = 1'b1;
        end
      end
    end else begin
      w_q_nxt = w_q;
    end
  end

  dff_sync_r #(.WIDTH(WIDTH)) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .d   (w_q_nxt),
    .q   (w_q),
    .q_b (w_q_b)
  );

  dff_sync_r #(.WIDTH(1)) u_wrap_reg (
    .clk (clk),
    .rst (rst),
    .d   (w_wrap_nxt),
    .q   (w_wrap),
    .q_b (w_wrap_b)
  );

  dff_sync_r #(.WIDTH(1)) u_sat_reg (
    .clk (clk),
    .rst (rst),
    .d   (w_sat_nxt),
    .q   (w_sat),
    .q_b (w_sat_b)
  );

  // Terminal count follows up_dn combinationally; sampled by consumers at the edge.
  assign tc      = ((up_dn == DIR_UP) && w_at_max) || ((up_dn == DIR_DN) && w_at_zero);
  assign q       = w_q;
  assign wrap    = w_wrap;
  assign sat_hit = w_sat;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed checks of the modulo-10 counter plus a full-range modulo-16 instance.
module tb_sync_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q10;
  logic       tc10;
  logic       wrap10;
  logic       sat10;
  logic [3:0] q16;
  logic       tc16;
  logic       wrap16;
  logic       sat16;

  int n_pass = 0;
  int n_total = 0;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .q(q10), .tc(tc10), .wrap(wrap10), .sat_hit(sat10)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .q(q16), .tc(tc16), .wrap(wrap16), .sat_hit(sat16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    // 1. reset overrides load and enable
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7; up_dn = 1'b1; sat_mode = 1'b0;
    step(); step();
    chk("rst_q", q10, 0);
    chk("rst_wrap", wrap10, 0);
    chk("rst_sat", sat10, 0);
    rst = 1'b0; load = 1'b0;
    step();
    chk("first_count", q10, 1);

    // 2. wrap going up
    load = 1'b1; load_val = 4'd8;
    step();
    chk("load8", q10, 8);
    load = 1'b0;
    step();
    chk("up_q9", q10, 9);
    chk("up_tc", tc10, 1);
    step();
    chk("up_wrap_q", q10, 0);
    chk("up_wrap_pulse", wrap10, 1);
    step();
    chk("up_after_q", q10, 1);
    chk("up_after_wrap", wrap10, 0);

    // 3. wrap going down
    load = 1'b1; load_val = 4'd0;
    step();
    chk("load0", q10, 0);
    load = 1'b0; up_dn = 1'b0;
    #1;
    chk("dn_tc", tc10, 1);
    step();
    chk("dn_wrap_q", q10, 9);
    chk("dn_wrap_pulse", wrap10, 1);
    step();
    chk("dn_after_q", q10, 8);
    chk("dn_after_wrap", wrap10, 0);
    chk("dn_tc_off", tc10, 0);

    // 4. saturation is sticky until load
    sat_mode = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd9;
    step();
    chk("sat_load9", q10, 9);
    chk("sat_clear", sat10, 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_hold_q", q10, 9);
      chk("sat_flag", sat10, 1);
      chk("sat_no_wrap", wrap10, 0);
    end
    up_dn = 1'b0; sat_mode = 1'b0;
    step();
    chk("sat_dn_q", q10, 8);
    chk("sat_sticky", sat10, 1);
    load = 1'b1; load_val = 4'd3;
    step();
    chk("sat_load3_q", q10, 3);
    chk("sat_load3_flag", sat10, 0);

    // 5. clamp on load and load beats enable
    up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd14;
    step();
    chk("clamp_q", q10, 9);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_q", q10, 9);
      chk("hold_wrap", wrap10, 0);
    end

    // 6. full binary range rollover
    rst = 1'b1;
    step();
    chk("full_rst_q", q16, 0);
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("full_q", q16, i % 16);
      chk("full_wrap", wrap16, (i == 16) ? 1 : 0);
      if (i == 15) chk("full_tc", tc16, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
